// File: rtl/csr_uart_tx.sv
// csr_uart_tx: CSR-mapped 8N1 UART transmitter with a byte FIFO and a polled status word.
// Latency: address N, read/modify N+1, csr_valid/csr_rdata N+2; start bit on tx one edge after the push.
// Backpressure: none on the bus; a push to a full FIFO is dropped and sets sticky ovf (cleared by a status read).
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   csr_addr                 CSR address, one cycle ahead of csr_read/csr_modify
//   csr_read, csr_modify     read strobe; modify op (1 = write csr_wdata[7:0] into the FIFO)
//   csr_wdata                write data, only [7:0] used
//   csr_rdata, csr_valid     status word {full, busy, ovf, ..., fill count at [DEPTH_LOG+8:8]}, zero when not valid
//   tx                       registered serial line, idles high
//   tx_idle                  FIFO empty and shifter idle
// Optional: CSR_UART_SIM_PRINT_EN echoes every accepted byte with $write at the push edge.
module csr_uart_tx #(
  parameter logic [11:0] CSR_ADDR  = 12'hbc0,
  parameter int          DIVISOR   = 434,
  parameter int          DEPTH_LOG = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        csr_read,
  input  logic [2:0]  csr_modify,
  input  logic [31:0] csr_wdata,
  input  logic [11:0] csr_addr,
  output logic [31:0] csr_rdata,
  output logic        csr_valid,
  output logic        tx,
  output logic        tx_idle
);

  localparam int DEPTH = 1 << DEPTH_LOG;
  localparam int DIV_W = $clog2(DIVISOR);

  typedef enum logic {IDLE, SHIFT} state_t;

  logic [11:0]          q_addr;
  logic [7:0]           mem [DEPTH];
  logic [DEPTH_LOG-1:0] wr_ptr;
  logic [DEPTH_LOG-1:0] rd_ptr;
  logic [DEPTH_LOG:0]   count;
  logic                 ovf;

  state_t               state;
  logic [9:0]           shreg;
  logic [3:0]           bit_cnt;
  logic [DIV_W-1:0]     div_cnt;

  logic                 hit;
  logic                 push_req;
  logic                 rd_req;
  logic                 fifo_empty;
  logic                 fifo_full;
  logic                 frame_end;
  logic                 pop;
  logic                 push_ok;
  logic [31:0]          status;
  logic                 unused_wdata;

  assign unused_wdata = ^csr_wdata[31:8];

  assign hit        = (q_addr == CSR_ADDR);
  assign push_req   = hit && (csr_modify == 3'd1);
  assign rd_req     = hit && csr_read;
  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == (DEPTH_LOG+1)'(DEPTH));
  // Last cycle of the stop bit: the next frame may be loaded on this edge so
  // back-to-back bytes leave no idle gap on the line.
  assign frame_end  = (state == SHIFT) && (div_cnt == '0) && (bit_cnt == 4'd9);
  assign pop        = !fifo_empty && ((state == IDLE) || frame_end);
  // A pop in the same cycle frees the slot, so a push while full is still accepted.
  assign push_ok    = push_req && (!fifo_full || pop);
  assign tx_idle    = fifo_empty && (state == IDLE);

  always_comb begin
    status = '0;
    status[31] = fifo_full;
    status[30] = !tx_idle;
    status[29] = ovf;
    status[DEPTH_LOG+8:8] = count;
  end

  // CSR address stage, read response and sticky overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_addr    <= '0;
      csr_valid <= 1'b0;
      csr_rdata <= '0;
      ovf       <= 1'b0;
    end else begin
      q_addr    <= csr_addr;
      csr_valid <= rd_req;
      csr_rdata <= rd_req ? status : '0;
      // Set wins over the read-clear so an overflow is never lost.
      if (push_req && !push_ok)
        ovf <= 1'b1;
      else if (rd_req)
        ovf <= 1'b0;
    end
  end

  // FIFO storage has no reset; validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (push_ok)
      mem[wr_ptr] <= csr_wdata[7:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Shifter: shreg[0] is always the bit currently on tx.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      tx      <= 1'b1;
      shreg   <= '1;
      bit_cnt <= '0;
      div_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            shreg   <= {1'b1, mem[rd_ptr], 1'b0};
            tx      <= 1'b0;
            bit_cnt <= '0;
            div_cnt <= DIV_W'(DIVISOR - 1);
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          if (div_cnt != '0) begin
            div_cnt <= div_cnt - 1'b1;
          end else if (bit_cnt == 4'd9) begin
            if (pop) begin
              shreg   <= {1'b1, mem[rd_ptr], 1'b0};
              tx      <= 1'b0;
              bit_cnt <= '0;
              div_cnt <= DIV_W'(DIVISOR - 1);
            end else begin
              tx    <= 1'b1;
              state <= IDLE;
            end
          end else begin
            shreg   <= {1'b1, shreg[9:1]};
            tx      <= shreg[1];
            div_cnt <= DIV_W'(DIVISOR - 1);
            bit_cnt <= bit_cnt + 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CSR_UART_SIM_PRINT_EN
  always_ff @(posedge clk) begin
    if (!rst && push_ok)
      $write("%c", csr_wdata[7:0]);
  end
`else
`endif

endmodule

// File: tb/tb_csr_uart_tx.sv
module tb_csr_uart_tx;
  localparam int          DIV = 4;
  localparam int          DL  = 2;
  localparam logic [11:0] A   = 12'hbc0;

  logic        clk = 1'b0;
  logic        rst;
  logic        csr_read;
  logic [2:0]  csr_modify;
  logic [31:0] csr_wdata;
  logic [11:0] csr_addr;
  logic [31:0] csr_rdata;
  logic        csr_valid;
  logic        tx;
  logic        tx_idle;

  int total = 0;
  int bad   = 0;
  bit started = 0;

  logic [7:0]  exp_bytes [$];
  logic [31:0] exp_rd    [$];

  csr_uart_tx #(.CSR_ADDR(A), .DIVISOR(DIV), .DEPTH_LOG(DL)) dut (
    .clk(clk), .rst(rst), .csr_read(csr_read), .csr_modify(csr_modify),
    .csr_wdata(csr_wdata), .csr_addr(csr_addr), .csr_rdata(csr_rdata),
    .csr_valid(csr_valid), .tx(tx), .tx_idle(tx_idle)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, req);
    end
  endtask

  // Push edge is the third posedge; returns 1ns after it.
  task automatic csr_write(input logic [7:0] b, input bit exp_tx);
    @(posedge clk); #1 csr_addr = A; csr_modify = 3'd0;
    @(posedge clk); #1 csr_modify = 3'd1; csr_wdata = {24'hABCDEF, b};
    if (exp_tx) exp_bytes.push_back(b);
    @(posedge clk); #1 csr_modify = 3'd0; csr_addr = 12'h000;
  endtask

  task automatic csr_rd(input logic [31:0] exp_status);
    @(posedge clk); #1 csr_addr = A;
    @(posedge clk); #1 csr_read = 1'b1;
    exp_rd.push_back(exp_status);
    @(posedge clk); #1 csr_read = 1'b0;
    @(negedge clk); check("valid_at_n2", csr_valid, 1'b1);
    @(negedge clk); check("valid_gone_n3", csr_valid, 1'b0);
  endtask

  // UART monitor: decodes each frame from per-cycle samples, checks bit timing.
  initial begin : uart_mon
    logic [10*DIV-1:0] smp;
    logic [7:0]        dbyte;
    logic [7:0]        eb;
    bit                aborted;
    bit                shape_ok;
    forever begin
      @(negedge clk);
      if (rst !== 1'b0 || tx !== 1'b0) continue;
      smp[0] = tx;
      aborted = 0;
      for (int i = 1; i < 10*DIV; i++) begin
        @(negedge clk);
        if (rst) aborted = 1;
        smp[i] = tx;
      end
      if (!aborted) begin
        shape_ok = 1;
        for (int j = 0; j < 10; j++)
          for (int k = 0; k < DIV; k++)
            if (smp[j*DIV+k] !== smp[j*DIV]) shape_ok = 0;
        if (smp[0] !== 1'b0 || smp[9*DIV] !== 1'b1) shape_ok = 0;
        for (int b = 0; b < 8; b++) dbyte[b] = smp[(b+1)*DIV];
        if (exp_bytes.size() == 0) begin
          total++; bad++;
          $display("FAIL uart_unexpected_frame: got 0x%02h want none", dbyte);
        end else begin
          eb = exp_bytes.pop_front();
          check("uart_byte", dbyte, eb);
          check("uart_frame_shape", shape_ok, 1'b1);
        end
      end
    end
  end

  // CSR response monitor.
  initial begin : csr_mon
    logic [31:0] er;
    forever begin
      @(negedge clk);
      if (!started || rst) continue;
      if (csr_valid === 1'b1) begin
        if (exp_rd.size() == 0) begin
          total++; bad++;
          $display("FAIL csr_unexpected_valid: got 0x%08h want no response", csr_rdata);
        end else begin
          er = exp_rd.pop_front();
          check("csr_rdata", csr_rdata, er);
        end
      end else if (csr_rdata !== 32'h0) begin
        check("rdata_zero_when_invalid", csr_rdata, 32'h0);
      end
    end
  end

  initial begin : timeout
    #200000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int k;
    rst = 1'b1; csr_read = 1'b0; csr_modify = 3'd0; csr_wdata = '0; csr_addr = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0; started = 1;

    // Reset state
    @(negedge clk);
    check("rst_tx", tx, 1'b1);
    check("rst_tx_idle", tx_idle, 1'b1);
    check("rst_valid", csr_valid, 1'b0);
    check("rst_rdata", csr_rdata, 32'h0);
    csr_rd(32'h0000_0000);

    // Single byte: start bit at E+1, tx_idle back at E+41
    csr_write(8'h55, 1);
    @(negedge clk);
    check("idle_falls_at_push", tx_idle, 1'b0);
    check("tx_high_at_push", tx, 1'b1);
    @(negedge clk); k = 1;
    check("start_bit_at_e1", tx, 1'b0);
    while (tx_idle !== 1'b1 && k < 200) begin @(negedge clk); k++; end
    check("single_idle_edge", k, 41);

    // Back-to-back: 0x41, 0x42 on consecutive cycles, 80 cycles, no gap
    @(posedge clk); #1 csr_addr = A;
    @(posedge clk); #1 csr_modify = 3'd1; csr_wdata = 32'h41; exp_bytes.push_back(8'h41);
    @(posedge clk); #1 csr_wdata = 32'h42; exp_bytes.push_back(8'h42);
    @(posedge clk); #1 csr_modify = 3'd0; csr_addr = 12'h000;
    k = 1;
    @(negedge clk);
    while (tx_idle !== 1'b1 && k < 300) begin @(negedge clk); k++; end
    check("b2b_idle_edge", k, 81);

    // Fill and overflow: 6 pipelined writes, 1 shifting, 4 queued, 1 dropped
    @(posedge clk); #1 csr_addr = A;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1 csr_modify = 3'd1; csr_wdata = 32'h10 + i;
      if (i < 5) exp_bytes.push_back(8'h10 + 8'(i));
    end
    @(posedge clk); #1 csr_modify = 3'd0;
    csr_rd(32'hE000_0400);
    csr_rd(32'hC000_0400);
    k = 0;
    while (tx_idle !== 1'b1 && k < 1000) begin @(negedge clk); k++; end
    check("fill_drained", tx_idle, 1'b1);

    // Miss: address 0xbc1 gives no response
    @(posedge clk); #1 csr_addr = 12'hbc1;
    @(posedge clk); #1 csr_read = 1'b1;
    @(posedge clk); #1 csr_read = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); check("miss_no_valid", csr_valid, 1'b0);
    end

    // Ignored op: modify=2 with a hit pushes nothing
    @(posedge clk); #1 csr_addr = A;
    @(posedge clk); #1 csr_modify = 3'd2; csr_wdata = 32'hFF;
    @(posedge clk); #1 csr_modify = 3'd0;
    repeat (5) @(negedge clk);
    check("ign_tx_high", tx, 1'b1);
    check("ign_idle", tx_idle, 1'b1);
    csr_rd(32'h0000_0000);

    // Reset mid-frame aborts the frame and discards queued bytes
    csr_write(8'h99, 0);
    csr_write(8'h77, 0);
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midrst_tx", tx, 1'b1);
    check("midrst_idle", tx_idle, 1'b1);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    csr_rd(32'h0000_0000);
    repeat (100) @(negedge clk);
    check("post_rst_tx", tx, 1'b1);
    check("post_rst_idle", tx_idle, 1'b1);

    check("uart_queue_empty", exp_bytes.size(), 0);
    check("csr_queue_empty", exp_rd.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/csr_uart_tx.md
# csr_uart_tx

CSR-mapped UART transmitter that replaces the bench-only character sink with a synthesizable peripheral. It sits on the Pipeline CSR bus beside CsrCounter and accepts bytes through a parametrised FIFO. Bytes are serialised 8N1 on a `tx` pin at a programmable bit period. Software polls a status word in the same CSR for flow control and drain detection.

## Interface
Parameters:
- `CSR_ADDR`, default 12'hbc0: CSR address decoded by the block.
- `DIVISOR`, default 434: clock cycles per UART bit. Must be ≥ 2.
- `DEPTH_LOG`, default 4: FIFO holds 2**DEPTH_LOG bytes. Range 1..8.

Ports:
- Clocking and reset: one clock; reset is synchronous and active-high.
- `clk`, input, 1: clock. All state updates on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `csr_read`, input, 1: read strobe. Qualified by the address registered in the previous cycle.
- `csr_modify`, input, 3: modify op, qualified by the registered address. Value 1 is a write; any other value writes nothing.
- `csr_wdata`, input, 32: write data. Only [7:0] is used.
- `csr_addr`, input, 12: CSR address, presented one cycle ahead of read/modify.
- `csr_rdata`, output, 32: status word. Zero whenever `csr_valid`=0.
- `csr_valid`, output, 1: asserted for an address hit. OR'd with other CSR responders.
- `tx`, output, 1: serial line, registered. Idles high.
- `tx_idle`, output, 1: high when the FIFO is empty and the shifter is idle.

## Operation
- Address stage: `q_addr <= csr_addr` every cycle. The block hits when `q_addr == CSR_ADDR`.
- Write: a hit with `csr_modify==1` pushes `csr_wdata[7:0]`.
  - If the FIFO is full, the byte is dropped and sticky `ovf` is set.
  - `csr_modify` of 2, 3 or other nonzero values with a hit does nothing. This is required for csrrs/csrrc with x0.
- Read: a hit with `csr_read` registers `csr_valid=1` for the next cycle.
  - `csr_rdata` carries the status sampled at the read cycle:
    - [31] full
    - [30] busy (= !tx_idle)
    - [29] ovf
    - [DEPTH_LOG+8:8] fill count (0..2**DEPTH_LOG)
    - all other bits 0
  - A read clears `ovf` at the same edge.
  - If an overflow occurs in the same cycle as the read, `ovf` stays set. Set wins over clear.
- FIFO: circular buffer with DEPTH_LOG-bit read/write pointers that wrap modulo 2**DEPTH_LOG, plus a DEPTH_LOG+1-bit count.
  - A push and a pop in the same cycle: both take effect and the count is unchanged.
  - A push to an empty FIFO while the shifter is loading is legal.
- Shifter FSM states:
  - IDLE
    - If the FIFO is non-empty: pop, load {stop=1, data, start=0} into a 10-bit shift register, `tx <= 0`, bit counter=0, divider=DIVISOR-1, go to SHIFT.
    - Otherwise stay in IDLE.
  - SHIFT: divider counts down.
    - At 0: shift right, drive the next bit onto `tx`, reload the divider, increment the bit counter.
    - After the stop bit has lasted DIVISOR cycles, go to IDLE.
- Data is sent LSB first. Frame length is exactly 10*DIVISOR cycles, with no gap between back-to-back frames.

## Timing
- Reset values:
  - outputs: `tx`=1, `csr_valid`=0, `csr_rdata`=0, `tx_idle`=1
  - internal: FIFO empty, pointers 0, `ovf`=0, FSM IDLE
  - `q_addr`=0
- Reset mid-frame aborts the transmission. `tx` returns high on the reset edge and FIFO contents are discarded.
- CSR latency:
  - Address in cycle N.
  - read/modify in cycle N+1.
  - `csr_valid`/`csr_rdata` valid in cycle N+2.
  - A push is visible in the count from N+2.
- Write-to-line latency, empty FIFO and idle shifter:
  - Push edge E.
  - Start bit driven from edge E+1.
  - Byte occupies `tx` from edge E+1 to edge E+1+10*DIVISOR.
- `tx_idle` falls at push edge E and rises at the edge ending the last stop bit.
- Full boundary: the FIFO holds exactly 2**DEPTH_LOG bytes. A push while full with no pop in the same cycle sets `ovf`. A push in the same cycle as a pop is accepted.

## Configuration
- `CSR_UART_SIM_PRINT_EN`
  - Defined: each accepted push also executes `$write("%c", byte)` at the push edge. Dropped bytes are not printed. Simulation-only code; the line output is unchanged.
  - Undefined: no simulation system tasks are compiled. The block is purely synthesizable.

## Test plan
- Reset: assert `rst` for 3 cycles during a frame -> `tx`=1, `tx_idle`=1, status read returns 0x00000000.
- Single byte (DIVISOR=4): write 0x55 -> from edge E+1, `tx` shows 0,1,0,1,0,1,0,1,0,1, each held 4 cycles, 40 cycles total. `tx_idle` rises at E+41.
- Back-to-back (DIVISOR=4): write 0x41 then 0x42 on consecutive cycles -> two frames, 80 cycles total, no idle gap. Decoded bytes are 0x41, 0x42.
- Fill and overflow (DEPTH_LOG=2, DIVISOR=100): write 6 bytes quickly -> 1 byte moves to the shifter, 4 are queued, 1 is dropped. Read returns [31]=1, [30]=1, [29]=1, count=4. A second read shows [29]=0.
- Status read latency: address 0xbc0 in cycle N, `csr_read` in N+1 -> `csr_valid`=1 only in N+2. Address 0xbc1 -> `csr_valid` stays 0.
- Ignored ops: a hit with `csr_modify`=2 and wdata 0xFF -> count stays 0, `tx` stays high. With `CSR_UART_SIM_PRINT_EN` defined, a write of 0x0A prints exactly one newline.
